// File: rtl/lfsr_pkg.sv
// -----------------------------------------------------------------------------
// lfsr_pkg
// Shared definitions for the lfsr_gen block:
//   MAX_WIDTH   - largest supported LFSR state width
//   lfsr_mode_e - feedback topology selector (only FIBONACCI today, reserved)
//   taps(w)     - maximal-length tap mask for widths 3..16. Bit (t-1) is set
//                 for every tap t, so feedback = ^(q & taps(w)).
// -----------------------------------------------------------------------------
package lfsr_pkg;

  localparam int MAX_WIDTH = 16;

  typedef enum logic {
    FIBONACCI = 1'b0
  } lfsr_mode_e;

  // Maximal-length polynomials (one primitive polynomial per width).
  // Unsupported widths return an all-zero mask and are rejected at elaboration.
  function automatic logic [MAX_WIDTH-1:0] taps(int w);
    case (w)
      3:       taps = 16'h0006;  // taps 3,2
      4:       taps = 16'h000C;  // taps 4,3
      5:       taps = 16'h0014;  // taps 5,3
      6:       taps = 16'h0030;  // taps 6,5
      7:       taps = 16'h0060;  // taps 7,6
      8:       taps = 16'h00B8;  // taps 8,6,5,4
      9:       taps = 16'h0110;  // taps 9,5
      10:      taps = 16'h0240;  // taps 10,7
      11:      taps = 16'h0500;  // taps 11,9
      12:      taps = 16'h0829;  // taps 12,6,4,1
      13:      taps = 16'h100D;  // taps 13,4,3,1
      14:      taps = 16'h2015;  // taps 14,5,3,1
      15:      taps = 16'h6000;  // taps 15,14
      16:      taps = 16'hD008;  // taps 16,15,13,4
      default: taps = 16'h0000;
    endcase
  endfunction

endpackage

// File: rtl/lfsr_gen_next.sv
// -----------------------------------------------------------------------------
// lfsr_gen_next
// Purely combinational single Fibonacci shift.
// Ports:
//   i_q    [WIDTH]  current state
//   i_mask [WIDTH]  tap mask (bit t-1 set for tap t)
//   o_q    [WIDTH]  state after one shift: {i_q[WIDTH-2:0], ^(i_q & i_mask)}
// -----------------------------------------------------------------------------
module lfsr_next #(
  parameter int WIDTH = 5
) (
  input  logic [WIDTH-1:0] i_q,
  input  logic [WIDTH-1:0] i_mask,
  output logic [WIDTH-1:0] o_q
);

  logic w_fb;

  assign w_fb = ^(i_q & i_mask);
  assign o_q  = {i_q[WIDTH-2:0], w_fb};

endmodule

// File: rtl/lfsr_gen.sv
// -----------------------------------------------------------------------------
// lfsr_gen
// Parametrised Fibonacci LFSR pseudo-random generator with seed load, enable,
// STEPS shifts per clock, all-zero lockup recovery, period (wrap) detection and
// an enabled-cycle counter.
// Parameters:
//   WIDTH  state width, 3..16
//   STEPS  shifts applied per enabled clock, 1..WIDTH
//   SEED   reset / lockup-recovery state, non-zero
// Ports:
//   clk       in          rising-edge clock
//   reset     in          synchronous active-low reset
//   en        in          advance state by STEPS shifts
//   load      in          load seed_in (wins over en)
//   seed_in   in  [WIDTH] seed for load; zero is rejected and SEED substituted
//   q         out [WIDTH] current state (registered)
//   bit_out   out         previous q[WIDTH-1] (serial stream)
//   wrap      out         1-cycle pulse when state returns to the start state
//   lockup    out         1-cycle pulse when a zero state/seed was replaced
//   step_cnt  out [WIDTH] enabled cycles since last reset/load/wrap
// -----------------------------------------------------------------------------
module lfsr_gen
  import lfsr_pkg::*;
#(
  parameter int               WIDTH = 5,
  parameter int               STEPS = 1,
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] seed_in,
  output logic [WIDTH-1:0] q,
  output logic             bit_out,
  output logic             wrap,
  output logic             lockup,
  output logic [WIDTH-1:0] step_cnt
);

  // ---------------------------------------------------------------------------
  // Elaboration-time parameter checks
  // ---------------------------------------------------------------------------
  if (WIDTH < 3 || WIDTH > MAX_WIDTH) begin : g_bad_width
    $error("lfsr_gen: WIDTH %0d outside 3..%0d", WIDTH, MAX_WIDTH);
  end
  if (STEPS < 1 || STEPS > WIDTH) begin : g_bad_steps
    $error("lfsr_gen: STEPS %0d outside 1..WIDTH", STEPS);
  end
  if (SEED == '0) begin : g_bad_seed
    $error("lfsr_gen: SEED must be non-zero");
  end

  localparam logic [WIDTH-1:0] TAP_MASK = WIDTH'(taps(WIDTH));

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_start;     // state the current period is measured from
  logic [WIDTH-1:0] r_step_cnt;
  logic             r_bit_out;
  logic             r_wrap;
  logic             r_lockup;

  // ---------------------------------------------------------------------------
  // STEPS chained single shifts: w_chain[0] is the current state,
  // w_chain[STEPS] the state after this enabled cycle.
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] w_chain [STEPS+1];
  logic [WIDTH-1:0] w_next;
  logic             w_zero;

  assign w_chain[0] = r_q;

  for (genvar g = 0; g < STEPS; g++) begin : g_step
    lfsr_next #(
      .WIDTH (WIDTH)
    ) u_next (
      .i_q    (w_chain[g]),
      .i_mask (TAP_MASK),
      .o_q    (w_chain[g+1])
    );
  end

  assign w_next = w_chain[STEPS];
  // All-zero is the one state the LFSR can never leave; only an upset gets here.
  assign w_zero = (r_q == '0);

  // ---------------------------------------------------------------------------
  // Register update: reset > load > en > hold
  // ---------------------------------------------------------------------------
  // NOTE: every state register is assigned with <= so all of them see the
  // pre-edge values of r_q / r_start; mixing in = here would create ordering
  // dependent simulation results that synthesis would not reproduce.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_q        <= SEED;
      r_start    <= SEED;
      r_step_cnt <= '0;
      r_bit_out  <= 1'b0;
      r_wrap     <= 1'b0;
      r_lockup   <= 1'b0;
    end else if (load) begin
      r_step_cnt <= '0;
      r_wrap     <= 1'b0;
      if (seed_in != '0) begin
        r_q      <= seed_in;
        r_start  <= seed_in;
        r_lockup <= 1'b0;
      end else begin
        r_q      <= SEED;
        r_start  <= SEED;
        r_lockup <= 1'b1;
      end
    end else if (en) begin
      r_bit_out <= r_q[WIDTH-1];
      if (w_zero) begin
        // Recover from an illegal zero state as if SEED had been loaded.
        r_q        <= SEED;
        r_start    <= SEED;
        r_step_cnt <= '0;
        r_wrap     <= 1'b0;
        r_lockup   <= 1'b1;
      end else begin
        r_q      <= w_next;
        r_lockup <= 1'b0;
        if (w_next == r_start) begin
          r_step_cnt <= '0;
          r_wrap     <= 1'b1;
        end else begin
          r_step_cnt <= r_step_cnt + WIDTH'(1);
          r_wrap     <= 1'b0;
        end
      end
    end else begin
      r_wrap   <= 1'b0;
      r_lockup <= 1'b0;
    end
  end

  assign q        = r_q;
  assign bit_out  = r_bit_out;
  assign wrap     = r_wrap;
  assign lockup   = r_lockup;
  assign step_cnt = r_step_cnt;

endmodule

// File: tb/tb_lfsr_gen.sv
// -----------------------------------------------------------------------------
// tb_lfsr_gen
// Drives two lfsr_gen instances (WIDTH=5, SEED=01; STEPS=1 and STEPS=2) from the
// same inputs. A behavioural LFSR model predicts every output each cycle; the
// prediction is queued when inputs are applied and compared after the edge.
// Directed steps also compare against hand-derived constant sequences.
// -----------------------------------------------------------------------------
module tb_lfsr_gen;

  typedef struct packed {
    logic [4:0] q;
    logic [4:0] start;
    logic [4:0] cnt;
    logic       bit_out;
    logic       wrap;
    logic       lockup;
  } model_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       en = 1'b0;
  logic       load = 1'b0;
  logic [4:0] seed_in = '0;

  logic [4:0] q1, cnt1, q2, cnt2;
  logic       bo1, wr1, lk1, bo2, wr2, lk2;

  int n_checks = 0;
  int n_errors = 0;

  model_t m1 = '0;
  model_t m2 = '0;
  model_t sb1 [$];
  model_t sb2 [$];

  always #5 clk = ~clk;

  lfsr_gen #(.WIDTH(5), .STEPS(1), .SEED(5'h01)) dut1 (
    .clk(clk), .reset(reset), .en(en), .load(load), .seed_in(seed_in),
    .q(q1), .bit_out(bo1), .wrap(wr1), .lockup(lk1), .step_cnt(cnt1)
  );

  lfsr_gen #(.WIDTH(5), .STEPS(2), .SEED(5'h01)) dut2 (
    .clk(clk), .reset(reset), .en(en), .load(load), .seed_in(seed_in),
    .q(q2), .bit_out(bo2), .wrap(wr2), .lockup(lk2), .step_cnt(cnt2)
  );

  // x^5 + x^3 + 1 style Fibonacci shift: feedback from bits 4 and 2.
  function automatic logic [4:0] shift1(logic [4:0] s);
    return {s[3:0], s[4] ^ s[2]};
  endfunction

  function automatic model_t model_step(model_t m, logic rn, logic ld, logic e,
                                        logic [4:0] sd, int steps);
    model_t     n;
    logic [4:0] t;
    n        = m;
    n.wrap   = 1'b0;
    n.lockup = 1'b0;
    if (!rn) begin
      n.q = 5'h01; n.start = 5'h01; n.cnt = '0; n.bit_out = 1'b0;
    end else if (ld) begin
      n.cnt = '0;
      if (sd != '0) begin
        n.q = sd; n.start = sd;
      end else begin
        n.q = 5'h01; n.start = 5'h01; n.lockup = 1'b1;
      end
    end else if (e) begin
      n.bit_out = m.q[4];
      if (m.q == '0) begin
        n.q = 5'h01; n.start = 5'h01; n.cnt = '0; n.lockup = 1'b1;
      end else begin
        t = m.q;
        for (int i = 0; i < steps; i++) t = shift1(t);
        n.q = t;
        if (t == m.start) begin
          n.cnt = '0; n.wrap = 1'b1;
        end else begin
          n.cnt = m.cnt + 5'd1;
        end
      end
    end
    return n;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply the current inputs for one edge: predict, wait, compare.
  task automatic tick();
    model_t e1, e2;
    m1 = model_step(m1, reset, load, en, seed_in, 1);
    m2 = model_step(m2, reset, load, en, seed_in, 2);
    sb1.push_back(m1);
    sb2.push_back(m2);
    @(posedge clk);
    #1;
    e1 = sb1.pop_front();
    e2 = sb2.pop_front();
    check("s1_q",      32'(q1),   32'(e1.q));
    check("s1_bit",    32'(bo1),  32'(e1.bit_out));
    check("s1_wrap",   32'(wr1),  32'(e1.wrap));
    check("s1_lockup", 32'(lk1),  32'(e1.lockup));
    check("s1_cnt",    32'(cnt1), 32'(e1.cnt));
    check("s2_q",      32'(q2),   32'(e2.q));
    check("s2_bit",    32'(bo2),  32'(e2.bit_out));
    check("s2_wrap",   32'(wr2),  32'(e2.wrap));
    check("s2_lockup", 32'(lk2),  32'(e2.lockup));
    check("s2_cnt",    32'(cnt2), 32'(e2.cnt));
  endtask

  initial begin
    logic [4:0] exp_seq [5];
    logic [4:0] exp_bit [5];
    logic       seen [32];
    int         n_dist;
    int         n_wrap;

    // ---- 1. reset, then the first five STEPS=1 states -------------------
    reset = 1'b0; en = 1'b0; load = 1'b0;
    tick();
    check("rst_q",      32'(q1),   32'h01);
    check("rst_cnt",    32'(cnt1), 32'h0);
    check("rst_wrap",   32'(wr1),  32'h0);
    check("rst_lockup", 32'(lk1),  32'h0);
    check("rst_bit",    32'(bo1),  32'h0);

    exp_seq = '{5'h02, 5'h04, 5'h09, 5'h12, 5'h05};
    exp_bit = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    reset = 1'b1; en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("seq_q%0d", i),   32'(q1),  32'(exp_seq[i]));
      check($sformatf("seq_bit%0d", i), 32'(bo1), 32'(exp_bit[i]));
    end

    // ---- 2/5. full period: wrap exactly on enabled cycle 31 -------------
    reset = 1'b0; en = 1'b0;
    tick();
    reset = 1'b1; en = 1'b1;
    for (int i = 0; i < 32; i++) seen[i] = 1'b0;
    n_dist = 0;
    n_wrap = 0;
    for (int i = 1; i <= 31; i++) begin
      tick();
      if (!seen[q1]) n_dist++;
      seen[q1] = 1'b1;
      if (wr1) n_wrap++;
      if (i == 1) check("s2_first", 32'(q2), 32'h04);
      if (i == 2) check("s2_second", 32'(q2), 32'h12);
      if (i == 30) begin
        check("pre_wrap1", 32'(wr1), 32'h0);
        check("pre_wrap2", 32'(wr2), 32'h0);
      end
    end
    check("wrap1_31",   32'(wr1),  32'h1);
    check("wrap1_q",    32'(q1),   32'h01);
    check("wrap1_cnt",  32'(cnt1), 32'h0);
    check("wrap2_31",   32'(wr2),  32'h1);
    check("wrap2_q",    32'(q2),   32'h01);
    check("wrap_count", 32'(n_wrap), 32'd1);
    check("distinct",   32'(n_dist), 32'd31);
    check("no_zero",    32'(seen[0]), 32'h0);
    tick();
    check("wrap_pulse_end", 32'(wr1), 32'h0);

    // ---- 3. zero seed rejected, then load wins over en -------------------
    en = 1'b0; load = 1'b1; seed_in = 5'h00;
    tick();
    check("lk_q",   32'(q1),  32'h01);
    check("lk_on",  32'(lk1), 32'h1);
    load = 1'b0;
    tick();
    check("lk_off", 32'(lk1), 32'h0);
    load = 1'b1; en = 1'b1; seed_in = 5'h15;
    tick();
    check("ld_q",      32'(q1),   32'h15);
    check("ld_lockup", 32'(lk1),  32'h0);
    check("ld_cnt",    32'(cnt1), 32'h0);
    load = 1'b0;
    tick();
    tick();
    check("ld_cnt2", 32'(cnt1), 32'h2);

    // ---- 4. reset mid-run while enabled ----------------------------------
    reset = 1'b0; en = 1'b0;
    tick();
    reset = 1'b1; en = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    check("mid_q12", 32'(q1), 32'h12);
    reset = 1'b0;
    tick();
    check("mid_q",    32'(q1),   32'h01);
    check("mid_cnt",  32'(cnt1), 32'h0);
    check("mid_wrap", 32'(wr1),  32'h0);
    reset = 1'b1;

    // ---- 6. random enable / occasional load ------------------------------
    for (int i = 0; i < 300; i++) begin
      en      = 1'($urandom_range(0, 1));
      load    = ($urandom_range(0, 19) == 0);
      seed_in = 5'($urandom_range(0, 31));
      tick();
    end
    load = 1'b0; en = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
